// File: rtl/seq_mult_pkg.sv
// Shared constants for the sequential 4x4 shift-and-add multiplier.
package seq_mult_pkg;

    localparam int OP_W = 4;
    localparam logic [1:0] ITER_LAST = 2'd3;

    // Encoding 2'd3 is unused and falls back to IDLE in the FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_4bit.sv
// 4-bit ripple adder: {cout, sum} = addend_one + addend_two + carry_in.
module full_adder_4bit (
    input  logic [3:0] addend_one,
    input  logic [3:0] addend_two,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]     = addend_one[i] ^ addend_two[i] ^ carry[i];
        assign carry[i+1] = (addend_one[i] & addend_two[i]) |
                            (carry[i] & (addend_one[i] ^ addend_two[i]));
    end

    assign cout = carry[4];

endmodule

// File: rtl/seq_mult_4bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier around one 4-bit adder.
// Handshake: start is sampled only in IDLE; done pulses one cycle with product valid.
module seq_mult_4bit
    import seq_mult_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] multiplicand,
    input  logic [OP_W-1:0] multiplier,
    output logic [7:0]      product,
    output logic            busy,
    output logic            done,
    output logic [1:0]      fsm_state
);

    state_t          state;
    logic [OP_W-1:0] acc;
    logic            c;
    logic [OP_W-1:0] q;
    logic [OP_W-1:0] m;
    logic [1:0]      cnt;
    logic [7:0]      product_r;

    logic [OP_W-1:0] addend_two;
    logic [OP_W-1:0] sum;
    logic            cout;

    assign addend_two = q[0] ? m : '0;

    // c is cleared on accept and only ever has a zero shifted into it,
    // so feeding it as carry-in keeps the adder carry-in at 0.
    full_adder_4bit u_adder (
        .addend_one (acc),
        .addend_two (addend_two),
        .carry_in   (c),
        .sum        (sum),
        .cout       (cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            c         <= 1'b0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
            product_r <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        acc   <= '0;
                        c     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    {c, acc, q} <= {1'b0, cout, sum, q[OP_W-1:1]};
                    cnt         <= cnt + 2'd1;
                    if (cnt == ITER_LAST) begin
                        product_r <= {cout, sum, q[OP_W-1:1]};
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign product   = product_r;
    assign fsm_state = state;

endmodule
